// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end between the PC and the instruction cache.
//
// Holds the fetch PC and issues one read per cycle to the cache. A hit pushes {pc, inst}
// into a small output FIFO and advances the PC. A miss parks the stage in StMiss until the
// cache stops filling, and then the same PC is re-read. A redirect loads a new PC and flushes
// the FIFO. Decode consumes FIFO entries over a valid/ready handshake.
//
// Optional feature: define FETCH_PERF_COUNTERS_EN to add saturating hit/miss counters.
//
// Ports:
//   i_clock, i_reset         clock; synchronous active-high reset
//   o_ic_addr, o_ic_rd       cache read address and request
//   i_ic_inst, i_ic_busy,    cache data, line-fill busy, hit for the current read
//   i_ic_hit
//   i_redirect, i_redirect_pc  load a new PC and flush buffered instructions
//   o_valid, i_ready         decode handshake
//   o_inst, o_pc             FIFO head entry (registered)
//   o_hit_count, o_miss_count  perf counters (FETCH_PERF_COUNTERS_EN only)
module fetch_stage #(
    parameter int unsigned           ADDR_WIDTH = 12,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    output logic [ADDR_WIDTH-1:0] o_ic_addr,
    output logic                  o_ic_rd,
    input  logic [DATA_WIDTH-1:0] i_ic_inst,
    input  logic                  i_ic_busy,
    input  logic                  i_ic_hit,
    input  logic                  i_redirect,
    input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_inst,
    output logic [ADDR_WIDTH-1:0] o_pc
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]           o_hit_count,
    output logic [31:0]           o_miss_count
`endif
);

    localparam int unsigned     PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned     CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {StReq, StMiss} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_inst_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic issue;
    logic push;
    logic pop;

    always_comb begin
        // Reset is folded in so the request line stays low while reset is held.
        issue   = !i_reset && (state_q == StReq) && !i_ic_busy && (count_q < DEPTH_CNT)
                  && !i_redirect;
        push    = issue && i_ic_hit;
        pop     = (count_q != '0) && i_ready;
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StReq: begin
                if (issue && !i_ic_hit) begin
                    state_d = StMiss;
                end else if (push) begin
                    pc_d = pc_q + ADDR_WIDTH'(1);
                end
            end
            StMiss: begin
                // The outstanding fill finishes even across a redirect.
                if (!i_ic_busy) begin
                    state_d = StReq;
                end
            end
        endcase
        if (i_redirect) begin
            pc_d = i_redirect_pc;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= StReq;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_inst_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (i_redirect) begin
                // Flush wins over any pop in the same cycle.
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    fifo_pc_q[wr_ptr_q]   <= pc_q;
                    fifo_inst_q[wr_ptr_q] <= i_ic_inst;
                    wr_ptr_q              <= wr_ptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign o_ic_addr = pc_q;
    assign o_ic_rd   = issue;
    assign o_valid   = (count_q != '0);
    assign o_inst    = fifo_inst_q[rd_ptr_q];
    assign o_pc      = fifo_pc_q[rd_ptr_q];

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    // issue already excludes redirect cycles, so squashed reads are never counted.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (push && (hit_count_q != '1)) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (issue && !i_ic_hit && (miss_count_q != '1)) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign o_hit_count  = hit_count_q;
    assign o_miss_count = miss_count_q;
`endif

endmodule
